spi_rdid_slave: RTL and testbench

//  SPI mode-0 slave (flash-ID responder) answering the RDID instruction (0x9F) with a 3-byte

---
 rtl/spi_rdid_slave.sv | 150 +++++++++++++++
 tb/tb_spi_rdid_slave.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_rdid_slave.sv
// SPI mode-0 flash-ID slave: answers opcode RDID_CMD with a repeating {MFG_ID, MEM_TYPE, MEM_CAP}.
// Latency: pin edge to internal event is 2-3 clk (2-flop sync plus edge detect); spi_miso is registered.
// No backpressure: the SPI master owns the timing, and SCK must be at least 8 clk periods.
module spi_rdid_slave #(
   parameter logic [7:0] MFG_ID   = 8'h20,
   parameter logic [7:0] MEM_TYPE = 8'h20,
   parameter logic [7:0] MEM_CAP  = 8'h15,
   parameter logic [7:0] RDID_CMD = 8'h9F
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_clk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       miso_oe,
   output logic       cmd_valid,
   output logic [7:0] cmd_byte,
   output logic       busy,
   output logic [7:0] rdid_count
);

   typedef enum logic [1:0] {IDLE, CMD, RESP, IGNORE} state_t;

   state_t      state, state_next;

   logic        sck_s1, sck_s2, sck_d;
   logic        cs_s1, cs_s2, cs_d;
   logic        mosi_s1, mosi_s2;

   logic [2:0]  bit_cnt;
   logic [6:0]  cmd_sr;
   logic [23:0] tx_sr;
   logic [4:0]  tx_cnt;

   logic        sck_rise, sck_fall, cs_fall, cs_rise;
   logic [7:0]  opcode;
   logic        is_rdid;
   logic        cmd_done;

   // Synchronise the SPI pins; reset values match an idle bus so no spurious edge appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_s1  <= 1'b0;
         sck_s2  <= 1'b0;
         sck_d   <= 1'b0;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_d    <= 1'b1;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         sck_s1  <= spi_clk;
         sck_s2  <= sck_s1;
         sck_d   <= sck_s2;
         cs_s1   <= spi_cs_n;
         cs_s2   <= cs_s1;
         cs_d    <= cs_s2;
         mosi_s1 <= spi_mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   assign sck_rise = sck_s2 & ~sck_d;
   assign sck_fall = ~sck_s2 & sck_d;
   assign cs_fall  = ~cs_s2 & cs_d;
   assign cs_rise  = cs_s2 & ~cs_d;
   assign opcode   = {cmd_sr, mosi_s2};
   assign is_rdid  = (opcode == RDID_CMD);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state decode; a CS release always wins over any SCK edge in the same clk.
   always_comb begin
      state_next = state;
      miso_oe    = 1'b0;
      cmd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) state_next = CMD;
         end
         CMD: begin
            if (cs_rise) begin
               state_next = IDLE;
            end else if (sck_rise && bit_cnt == 3'd0) begin
               cmd_done   = 1'b1;
               state_next = is_rdid ? RESP : IGNORE;
            end
         end
         RESP: begin
            miso_oe = 1'b1;
            if (cs_rise) state_next = IDLE;
         end
         IGNORE: begin
            if (cs_rise) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Opcode shifter, response shifter and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt    <= 3'd7;
         cmd_sr     <= 7'd0;
         tx_sr      <= 24'd0;
         tx_cnt     <= 5'd23;
         spi_miso   <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_byte   <= 8'd0;
         busy       <= 1'b0;
         rdid_count <= 8'd0;
      end else begin
         cmd_valid <= cmd_done;

         if (cs_rise) begin
            busy <= 1'b0;
         end else if (state == IDLE && cs_fall) begin
            busy    <= 1'b1;
            bit_cnt <= 3'd7;
         end

         if (state == CMD && !cs_rise && sck_rise) begin
            cmd_sr  <= opcode[6:0];
            bit_cnt <= bit_cnt - 3'd1;
         end

         if (cmd_done) begin
            cmd_byte <= opcode;
            if (is_rdid) begin
               tx_sr  <= {MFG_ID, MEM_TYPE, MEM_CAP};
               tx_cnt <= 5'd23;
               if (rdid_count != 8'hFF) rdid_count <= rdid_count + 8'd1;
            end
         end

         if (state != RESP || cs_rise) begin
            spi_miso <= 1'b0;
         end else begin
            if (sck_fall) spi_miso <= tx_sr[tx_cnt];
            if (sck_rise) tx_cnt <= (tx_cnt == 5'd0) ? 5'd23 : tx_cnt - 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_spi_rdid_slave.sv
// Directed bench for spi_rdid_slave acting as a mode-0 SPI master with SCK period 8 clk.
// Expected MISO/OE bytes are queued as each byte is driven and popped as it is received.
module tb_spi_rdid_slave;

   logic       clk = 1'b0;
   logic       reset;
   logic       spi_clk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic       miso_oe;
   logic       cmd_valid;
   logic [7:0] cmd_byte;
   logic       busy;
   logic [7:0] rdid_count;

   int n_assert = 0;
   int n_fail   = 0;
   int cv_cnt   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] oe_q[$];

   always #5 clk = ~clk;

   spi_rdid_slave dut (
      .clk        (clk),
      .reset      (reset),
      .spi_clk    (spi_clk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .miso_oe    (miso_oe),
      .cmd_valid  (cmd_valid),
      .cmd_byte   (cmd_byte),
      .busy       (busy),
      .rdid_count (rdid_count)
   );

   // Count clk cycles with cmd_valid high (one per accepted opcode).
   always @(posedge clk) begin
      if (cmd_valid) cv_cnt <= cv_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Shift nbits MSB-first; MISO and OE are captured just before each SCK rise.
   task automatic xfer(input logic [7:0] mo, input int nbits,
                       output logic [7:0] mi, output logic [7:0] oe);
      mi = 8'h00;
      oe = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[7-i];
         repeat (4) @(negedge clk);
         mi = {mi[6:0], spi_miso};
         oe = {oe[6:0], miso_oe};
         spi_clk = 1'b1;
         repeat (4) @(negedge clk);
         spi_clk = 1'b0;
      end
   endtask

   task automatic frame(input logic [7:0] op, input int nresp);
      logic [7:0] mi, oe;
      logic [7:0] id [3];
      int         cv0;
      id[0] = 8'h20;
      id[1] = 8'h20;
      id[2] = 8'h15;
      cv0 = cv_cnt;
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      exp_q.push_back(8'h00);
      oe_q.push_back(8'h00);
      for (int k = 0; k < nresp; k++) begin
         exp_q.push_back(op == 8'h9F ? id[k % 3] : 8'h00);
         oe_q.push_back(op == 8'h9F ? 8'hFF : 8'h00);
      end
      xfer(op, 8, mi, oe);
      check("opcode_phase_miso", {24'd0, mi}, {24'd0, exp_q.pop_front()});
      check("opcode_phase_oe", {24'd0, oe}, {24'd0, oe_q.pop_front()});
      for (int k = 0; k < nresp; k++) begin
         xfer(8'h00, 8, mi, oe);
         check("resp_miso", {24'd0, mi}, {24'd0, exp_q.pop_front()});
         check("resp_oe", {24'd0, oe}, {24'd0, oe_q.pop_front()});
      end
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
      check("cmd_valid_pulses", cv_cnt - cv0, 32'd1);
      check("cmd_byte", {24'd0, cmd_byte}, {24'd0, op});
      check("busy_after_cs", {31'd0, busy}, 32'd0);
      check("oe_after_cs", {31'd0, miso_oe}, 32'd0);
      check("miso_after_cs", {31'd0, spi_miso}, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
      check({tag, "_oe"}, {31'd0, miso_oe}, 32'd0);
      check({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
      check({tag, "_cmd_byte"}, {24'd0, cmd_byte}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_rdid_count"}, {24'd0, rdid_count}, 32'd0);
   endtask

   initial begin
      logic [7:0] mi, oe;
      int         cv0;

      reset    = 1'b1;
      spi_clk  = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      #1;
      check_all_zero("reset");
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_all_zero("post_reset");

      // RDID frame: one full ID.
      frame(8'h9F, 3);
      check("rdid_count_1", {24'd0, rdid_count}, 32'd1);

      // Non-RDID opcode: MISO stays 0 and tri-stated, count unchanged.
      frame(8'h03, 3);
      check("rdid_count_after_03", {24'd0, rdid_count}, 32'd1);

      // 48 response clocks under one CS: ID repeats twice.
      frame(8'h9F, 6);
      check("rdid_count_2", {24'd0, rdid_count}, 32'd2);

      // CS glitch with no SCK edges.
      cv0 = cv_cnt;
      spi_cs_n = 1'b0;
      repeat (6) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
      check("glitch_cmd_valid", cv_cnt - cv0, 32'd0);
      check("glitch_rdid_count", {24'd0, rdid_count}, 32'd2);

      // Partial opcode of 5 bits, then a full frame.
      cv0 = cv_cnt;
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
      xfer(8'h9F, 5, mi, oe);
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (6) @(negedge clk);
      check("partial_cmd_valid", cv_cnt - cv0, 32'd0);
      check("partial_rdid_count", {24'd0, rdid_count}, 32'd2);
      check("partial_busy", {31'd0, busy}, 32'd0);
      frame(8'h9F, 3);
      check("rdid_count_3", {24'd0, rdid_count}, 32'd3);

      // Reset at response bit 10, then a fresh frame.
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
      xfer(8'h9F, 8, mi, oe);
      xfer(8'h00, 8, mi, oe);
      check("pre_reset_byte0", {24'd0, mi}, 32'h20);
      xfer(8'h00, 2, mi, oe);
      check("pre_reset_oe", {31'd0, miso_oe}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_all_zero("mid_resp_reset");
      spi_cs_n = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("after_reset_oe", {31'd0, miso_oe}, 32'd0);
      frame(8'h9F, 3);
      check("rdid_count_after_reset", {24'd0, rdid_count}, 32'd1);

      // 256 back-to-back RDID frames: count saturates at FF.
      for (int i = 0; i < 256; i++) begin
         frame(8'h9F, 1);
         if (i == 253) check("rdid_count_reaches_ff", {24'd0, rdid_count}, 32'hFF);
      end
      check("rdid_count_saturated", {24'd0, rdid_count}, 32'hFF);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
